fifo_uart_drain: RTL and testbench
==================================

# fifo_uart_drain

Downstream consumer stage for the 8-entry, 8-bit synchronous FIFO. It pops bytes from the FIFO with a one-cycle read handshake. Each byte goes out as an asynchronous serial frame: start bit, 8 data bits LSB first, optional even parity, stop bit. It sits between the FIFO read port and the device's serial TX pin.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535
- PARITY_EN, 0, 1 inserts an even-parity bit after data bit 7

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  permits new frames to start; does not abort a frame in progress
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  8  FIFO read data; valid the cycle after a read strobe
- fifo_rd_en  out  1  one-cycle read strobe to the FIFO
- tx  out  1  serial line; idles high
- busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse during the last cycle of the stop bit

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE → FETCH when enable=1 and fifo_empty=0, sampled at the clock edge.
- FETCH lasts exactly 1 cycle.
  - fifo_rd_en=1 only in FETCH (decoded from the registered state).
  - The FIFO presents the byte on fifo_data in the next cycle.
- LOAD lasts exactly 1 cycle.
  - fifo_data is captured into the 8-bit shift register.
  - If PARITY_EN=1, the parity bit (XOR of all 8 bits) is computed.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - A 3-bit index counts 0..7.
  - DATA → PARITY (if PARITY_EN=1) or → STOP after bit 7.
- PARITY: tx=parity bit for CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles. tx_done=1 in its final cycle. Exit:
  - → FETCH if enable=1 and fifo_empty=0
  - → IDLE otherwise
- Bit timer:
  - Counter reloads to 0 on every state entry.
  - A bit ends when the counter equals CLKS_PER_BIT-1.
  - Counter width is $clog2(CLKS_PER_BIT).
- tx is registered; it is 1 in IDLE, FETCH and LOAD.
- enable deasserted mid-frame: the frame completes normally; no further FETCH.
- fifo_empty asserting mid-frame: no effect until the STOP exit decision.
- At most one read strobe per frame. fifo_rd_en never asserts while fifo_empty=1 at the sampling edge.

## Timing
- Reset values (asserted asynchronously, held while rst=1): state=IDLE, tx=1, busy=0, fifo_rd_en=0, tx_done=0, counters and shift register 0.
- Reset mid-frame: tx returns high immediately and the frame is abandoned. The byte already popped is lost; this is accepted.
- Latency from the edge sampling enable=1 and fifo_empty=0: fifo_rd_en high the next cycle; tx falls 2 cycles after fifo_rd_en.
- Frame length from FETCH to STOP end:
  - 10×CLKS_PER_BIT+2 cycles without parity
  - 11×CLKS_PER_BIT+2 cycles with parity
- Back-to-back frames have a 2-cycle idle-high gap (FETCH+LOAD) between stop and the next start.
- busy rises the cycle after IDLE exits. It falls the cycle after STOP exits to IDLE, and stays high across back-to-back frames.

## Test plan
- Reset: rst=1 async, mid-cycle → tx=1, busy=0, fifo_rd_en=0 without waiting for a clock edge.
- Single byte 0xA5, CLKS_PER_BIT=4, PARITY_EN=0:
  - one fifo_rd_en pulse at cycle 0
  - tx bits 0, 1,0,1,0,0,1,0,1, 1, each 4 cycles, starting at cycle 2
  - tx_done at cycle 41; busy low at cycle 42
- Back-to-back 0x00 then 0xFF with FIFO non-empty:
  - second fifo_rd_en at cycle 42
  - tx high for exactly cycles 42-43
  - second start bit at cycle 44
- Enable drop: deassert enable during data bit 3 of 0x3C with bytes still queued → 0x3C finishes, no further fifo_rd_en, busy=0 after stop.
- Reset mid-frame: assert rst during bit 5 → tx=1 immediately; after release, the next frame starts from FETCH with the next FIFO byte.
- Parity: PARITY_EN=1, byte 0x07 → parity bit 1. Frame is 11×4+2=46 cycles; tx_done in its last stop cycle.

Source files
------------

// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops bytes from a synchronous FIFO and sends each one
// as a serial frame (start, 8 data LSB first, optional even parity, stop).
module fifo_uart_drain #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          bit_end;
    logic          go;
    logic          timed;

    assign bit_end = (cnt_q == LAST);
    assign go      = enable && !fifo_empty;
    assign timed   = (state_q == START) || (state_q == DATA) ||
                     (state_q == PARITY) || (state_q == STOP);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        case (state_q)
            IDLE: if (go) state_d = FETCH;
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d = fifo_data;
                par_d   = PARITY_EN ? ^fifo_data : 1'b0;
                state_d = START;
            end
            START: if (bit_end) begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: if (bit_end) state_d = go ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase

        // The counter restarts on every state entry and every bit boundary.
        if (timed && (state_d == state_q) && !bit_end) cnt_d = cnt_q + 1'b1;
        else                                            cnt_d = '0;

        // Outputs are computed from the next state so they come out of flops.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo_rd_en = (state_q == FETCH);
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: two instances (no parity / even parity) fed by
// behavioural FIFOs, compared cycle by cycle against a frame-level model.
module tb_fifo_uart_drain;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    logic en0, en1;
    logic emp0, emp1;
    logic [7:0] fd0, fd1;
    logic rd0, rd1, tx0, tx1, bz0, bz1, dn0, dn1;

    byte unsigned mem0 [0:1023];
    byte unsigned mem1 [0:1023];
    int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
    logic fl0 = 1'b0, fl1 = 1'b0;
    byte unsigned eb [0:15];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_uart_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut (
        .clk(clk), .rst(rst), .enable(en0), .fifo_empty(emp0),
        .fifo_data(fd0), .fifo_rd_en(rd0), .tx(tx0), .busy(bz0),
        .tx_done(dn0)
    );

    fifo_uart_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut_p (
        .clk(clk), .rst(rst), .enable(en1), .fifo_empty(emp1),
        .fifo_data(fd1), .fifo_rd_en(rd1), .tx(tx1), .busy(bz1),
        .tx_done(dn1)
    );

    // Synchronous FIFO models: read data appears the cycle after the strobe.
    assign emp0 = (rp0 == wp0);
    assign emp1 = (rp1 == wp1);

    always @(posedge clk) begin
        if (fl0) rp0 <= wp0;
        else if (rd0 && (rp0 != wp0)) begin
            fd0 <= mem0[rp0 % 1024];
            rp0 <= rp0 + 1;
        end
    end

    always @(posedge clk) begin
        if (fl1) rp1 <= wp1;
        else if (rd1 && (rp1 != wp1)) begin
            fd1 <= mem1[rp1 % 1024];
            rp1 <= rp1 + 1;
        end
    end

    task automatic push(input bit par, input byte unsigned b);
        if (par) begin
            mem1[wp1 % 1024] = b;
            wp1 = wp1 + 1;
        end else begin
            mem0[wp0 % 1024] = b;
            wp0 = wp0 + 1;
        end
    endtask

    task automatic flush();
        @(negedge clk);
        fl0 = 1'b1;
        fl1 = 1'b1;
        @(negedge clk);
        fl0 = 1'b0;
        fl1 = 1'b0;
    endtask

    // Expected {tx, rd_en, tx_done, busy} per cycle, built from frame rules.
    task automatic expect_stream(input bit par, input int first,
                                 input int nframes, input int drop_at,
                                 input int tail, input int limit,
                                 input string name);
        logic [3:0] ev[$];
        logic       bits[$];
        logic [3:0] got;
        logic [7:0] b;
        int         nb;
        for (int f = 0; f < nframes; f++) begin
            b = eb[first + f];
            ev.push_back(4'b1101);
            ev.push_back(4'b1001);
            bits = {};
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(b[i]);
            if (par) bits.push_back(^b);
            bits.push_back(1'b1);
            nb = bits.size();
            for (int j = 0; j < nb; j++)
                for (int k = 0; k < CPB; k++)
                    ev.push_back({bits[j], 1'b0,
                                  (j == nb - 1) && (k == CPB - 1), 1'b1});
        end
        for (int t = 0; t < tail; t++) ev.push_back(4'b1000);
        for (int c = 0; c < ev.size(); c++) begin
            if (limit >= 0 && c > limit) break;
            @(negedge clk);
            got = par ? {tx1, rd1, dn1, bz1} : {tx0, rd0, dn0, bz0};
            checks++;
            if (got !== ev[c]) begin
                errors++;
                $display("FAIL %s cycle %0d tx/rd/done/busy got %b expected %b",
                         name, c, got, ev[c]);
            end
            if (c == drop_at) begin
                if (par) en1 = 1'b0;
                else     en0 = 1'b0;
            end
        end
        if (limit < 0) begin
            en0 = 1'b0;
            en1 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en0 = 1'b0;
        en1 = 1'b0;
        #2;
        checks++;
        if ({tx0, bz0, rd0, dn0, tx1, bz1, rd1, dn1} !== 8'b1000_1000) begin
            errors++;
            $display("FAIL reset_state got %b expected %b",
                     {tx0, bz0, rd0, dn0, tx1, bz1, rd1, dn1}, 8'b1000_1000);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        eb[0] = 8'hA5;
        push(1'b0, 8'hA5);
        en0 = 1'b1;
        expect_stream(1'b0, 0, 1, -1, 4, -1, "single_a5");
    endtask

    task automatic test_back_to_back();
        eb[0] = 8'h00;
        eb[1] = 8'hFF;
        push(1'b0, 8'h00);
        push(1'b0, 8'hFF);
        en0 = 1'b1;
        expect_stream(1'b0, 0, 2, -1, 3, -1, "back_to_back");
    endtask

    task automatic test_enable_drop();
        eb[0] = 8'h3C;
        push(1'b0, 8'h3C);
        push(1'b0, 8'h11);
        push(1'b0, 8'h22);
        en0 = 1'b1;
        // cycle 19 lies inside data bit 3 (cycles 18..21)
        expect_stream(1'b0, 0, 1, 19, 6, -1, "enable_drop");
        flush();
    endtask

    task automatic test_reset_mid();
        eb[0] = 8'h5A;
        eb[1] = 8'hC3;
        eb[2] = 8'($urandom);
        for (int i = 0; i < 3; i++) push(1'b0, eb[i]);
        en0 = 1'b1;
        // cycles 26..29 carry data bit 5 (a 0 for 0x5A)
        expect_stream(1'b0, 0, 1, -1, 0, 27, "rst_mid_pre");
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({tx0, bz0, rd0} !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid_async tx/busy/rd got %b expected %b",
                     {tx0, bz0, rd0}, 3'b100);
        end
        @(negedge clk);
        rst = 1'b0;
        expect_stream(1'b0, 1, 2, -1, 3, -1, "rst_mid_post");
    endtask

    task automatic test_parity();
        eb[0] = 8'h07;
        push(1'b1, 8'h07);
        en1 = 1'b1;
        expect_stream(1'b1, 0, 1, -1, 3, -1, "parity_07");
    endtask

    task automatic test_random();
        int  n;
        bit  par;
        bit  drop;
        int  d;
        for (int r = 0; r < 10; r++) begin
            n    = $urandom_range(1, 4);
            par  = 1'($urandom_range(0, 1));
            drop = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                eb[i] = 8'($urandom);
                push(par, eb[i]);
            end
            if (par) en1 = 1'b1;
            else     en0 = 1'b1;
            if (drop) begin
                d = $urandom_range(0, 40);
                expect_stream(par, 0, 1, d, 4, -1, "random_drop");
                flush();
            end else begin
                expect_stream(par, 0, n, -1, 2, -1, "random_stream");
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_parity();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
